change_dispenser: RTL and testbench

Downstream payout stage of the vending machine. It accepts a change amount in cents from the vending FSM and pays it out one coin at a time through a handshake with the coin hopper, using the largest available denomination first (20, 10, 5). It tracks per-denomination coin stock and flags unpayable amounts, invalid amounts and hopper timeouts.

---
 rtl/vend_pkg.sv | 38 +++
 rtl/change_dispenser_if.sv | 26 ++
 rtl/coin_stock_counter.sv | 24 ++
 rtl/change_dispenser.sv | 148 ++++++++++++++
 tb/tb_change_dispenser.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes and values, dispenser states,
// and the item prices used across the vending blocks.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_5    = 2'd1,
        COIN_10   = 2'd2,
        COIN_20   = 2'd3
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_DONE
    } state_e;

    localparam int unsigned VAL_5  = 5;
    localparam int unsigned VAL_10 = 10;
    localparam int unsigned VAL_20 = 20;

    localparam int unsigned NUM_ITEMS   = 4;
    localparam int unsigned PRICE_WATER = 25;
    localparam int unsigned PRICE_SODA  = 35;
    localparam int unsigned PRICE_JUICE = 45;
    localparam int unsigned PRICE_SNACK = 50;

    function automatic int unsigned coin_value(coin_e c);
        case (c)
            COIN_5:  return VAL_5;
            COIN_10: return VAL_10;
            COIN_20: return VAL_20;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Payout bus between the vending FSM / coin hopper side and the change dispenser.
interface change_dispenser_if #(
    parameter int AMT_W = 6
);
    logic             change_valid;
    logic [AMT_W-1:0] change;
    logic             ready;
    logic             coin_req;
    logic [1:0]       coin_sel;
    logic             coin_ack;
    logic             refill;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       empty;

    modport master (
        output change_valid, change, coin_ack, refill,
        input  ready, coin_req, coin_sel, done, fault, remaining, empty
    );

    modport slave (
        input  change_valid, change, coin_ack, refill,
        output ready, coin_req, coin_sel, done, fault, remaining, empty
    );
endinterface

// File: rtl/coin_stock_counter.sv
// Per-denomination coin stock: loads a fixed fill level, decrements on each
// ejected coin and never wraps below zero.
module coin_stock_counter #(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic               clk,
    input  logic               load,
    input  logic               dec,
    output logic [STOCK_W-1:0] count,
    output logic               empty
);

    always_ff @(posedge clk) begin
        if (load) begin
            count <= STOCK_W'(STOCK_INIT);
            empty <= (STOCK_INIT == 0);
        end else if (dec && count != '0) begin
            count <= count - STOCK_W'(1);
            empty <= (count == STOCK_W'(1));
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time, largest denomination first,
// through a req/ack handshake with the coin hopper.
//
// state     | meaning
// ST_IDLE   | ready for a request; refill honoured here
// ST_SELECT | choose the next coin or finish
// ST_REQ    | coin_req high, waiting for coin_ack or timeout
// ST_DONE   | one-cycle done pulse
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 6,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AMT_W-1:0] AMT_5  = AMT_W'(VAL_5);
    localparam logic [AMT_W-1:0] AMT_10 = AMT_W'(VAL_10);
    localparam logic [AMT_W-1:0] AMT_20 = AMT_W'(VAL_20);

    state_e             state_q, state_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic               fault_q, fault_d;
    coin_e              sel_q, sel_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               ready_q, coin_req_q, done_q;

    logic [STOCK_W-1:0] cnt5, cnt10, cnt20;
    logic [2:0]         stock_empty;
    logic               load, ack_ok;

    // Reset doubles as a refill so the stocks start full.
    assign load   = rst || (state_q == ST_IDLE && bus.refill);
    assign ack_ok = (state_q == ST_REQ) && bus.coin_ack;

    coin_stock_counter #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_stock5 (
        .clk(clk), .load(load), .dec(ack_ok && sel_q == COIN_5),
        .count(cnt5), .empty(stock_empty[0])
    );
    coin_stock_counter #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_stock10 (
        .clk(clk), .load(load), .dec(ack_ok && sel_q == COIN_10),
        .count(cnt10), .empty(stock_empty[1])
    );
    coin_stock_counter #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_stock20 (
        .clk(clk), .load(load), .dec(ack_ok && sel_q == COIN_20),
        .count(cnt20), .empty(stock_empty[2])
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        fault_d = fault_q;
        sel_d   = sel_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.change_valid) begin
                    if (bus.change == '0) begin
                        rem_d   = '0;
                        fault_d = 1'b0;
                        state_d = ST_DONE;
                    end else if ((bus.change % AMT_5) != '0) begin
                        rem_d   = '0;
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = bus.change;
                        fault_d = 1'b0;
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                tmr_d   = TMR_W'(ACK_TIMEOUT - 1);
                state_d = ST_REQ;
                if (rem_q == '0) begin
                    sel_d   = COIN_NONE;
                    state_d = ST_DONE;
                end else if (rem_q >= AMT_20 && cnt20 != '0) begin
                    sel_d = COIN_20;
                end else if (rem_q >= AMT_10 && cnt10 != '0) begin
                    sel_d = COIN_10;
                end else if (rem_q >= AMT_5 && cnt5 != '0) begin
                    sel_d = COIN_5;
                end else begin
                    sel_d   = COIN_NONE;
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_REQ: begin
                if (bus.coin_ack) begin
                    rem_d   = rem_q - AMT_W'(coin_value(sel_q));
                    state_d = ST_SELECT;
                end else if (tmr_q == '0) begin
                    sel_d   = COIN_NONE;
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_DONE: begin
                sel_d   = COIN_NONE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            fault_q    <= 1'b0;
            sel_q      <= COIN_NONE;
            tmr_q      <= '0;
            ready_q    <= 1'b1;
            coin_req_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            fault_q    <= fault_d;
            sel_q      <= sel_d;
            tmr_q      <= tmr_d;
            ready_q    <= (state_d == ST_IDLE);
            coin_req_q <= (state_d == ST_REQ);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign bus.ready     = ready_q;
    assign bus.coin_req  = coin_req_q;
    assign bus.coin_sel  = sel_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.remaining = rem_q;
    assign bus.empty     = stock_empty;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (full stock 8 and stock 1) share the
// request stream; a greedy payout model predicts coins, fault, remaining and stock.
module tb_change_dispenser;

    localparam int AMT_W  = 6;
    localparam int ACK_TO = 15;
    localparam int LOGN   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if #(.AMT_W(AMT_W)) if_a ();
    change_dispenser_if #(.AMT_W(AMT_W)) if_b ();

    logic             cv  = 1'b0;
    logic [AMT_W-1:0] chg = '0;
    logic             rf  = 1'b0;
    logic             nz  = 1'b0;

    // nz injects a request+refill into instance A only, while it is busy.
    assign if_a.change_valid = cv | nz;
    assign if_a.change       = nz ? 6'd5 : chg;
    assign if_a.refill       = rf | nz;
    assign if_b.change_valid = cv;
    assign if_b.change       = chg;
    assign if_b.refill       = rf;

    change_dispenser #(.AMT_W(AMT_W), .STOCK_W(4), .STOCK_INIT(8), .ACK_TIMEOUT(ACK_TO)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    change_dispenser #(.AMT_W(AMT_W), .STOCK_W(4), .STOCK_INIT(1), .ACK_TIMEOUT(ACK_TO)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    logic [1:0]       rdy_v, req_v, done_v, flt_v;
    logic [AMT_W-1:0] rem_v [2];
    logic [2:0]       emp_v [2];
    logic [3:0]       stk_v [2][3];

    assign rdy_v  = {if_b.ready, if_a.ready};
    assign req_v  = {if_b.coin_req, if_a.coin_req};
    assign done_v = {if_b.done, if_a.done};
    assign flt_v  = {if_b.fault, if_a.fault};
    assign rem_v[0] = if_a.remaining;
    assign rem_v[1] = if_b.remaining;
    assign emp_v[0] = if_a.empty;
    assign emp_v[1] = if_b.empty;
    assign stk_v[0][0] = dut_a.u_stock5.count;
    assign stk_v[0][1] = dut_a.u_stock10.count;
    assign stk_v[0][2] = dut_a.u_stock20.count;
    assign stk_v[1][0] = dut_b.u_stock5.count;
    assign stk_v[1][1] = dut_b.u_stock10.count;
    assign stk_v[1][2] = dut_b.u_stock20.count;

    int checks   = 0;
    int failures = 0;

    int init_v [2] = '{8, 1};
    int stk     [2][3];
    int exp_log [2][16];
    int exp_n   [2];
    bit exp_flt [2];
    int exp_rem [2];
    int exp_req [2];

    int act_log [2][LOGN];
    int act_n   [2] = '{0, 0};
    bit ack_en = 1'b1;

    // Hopper models: ack after a random 0..3 cycle delay, logging {coin, remaining}.
    initial begin
        int wt = 0;
        if_a.coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && if_a.coin_req && !if_a.coin_ack) begin
                if (wt == 0) begin
                    if (act_n[0] < LOGN) act_log[0][act_n[0]] = int'(if_a.coin_sel) * 64 + int'(if_a.remaining);
                    act_n[0]++;
                    if_a.coin_ack = 1'b1;
                    wt = $urandom_range(0, 3);
                end else wt--;
            end else if_a.coin_ack = 1'b0;
        end
    end

    initial begin
        int wt = 0;
        if_b.coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && if_b.coin_req && !if_b.coin_ack) begin
                if (wt == 0) begin
                    if (act_n[1] < LOGN) act_log[1][act_n[1]] = int'(if_b.coin_sel) * 64 + int'(if_b.remaining);
                    act_n[1]++;
                    if_b.coin_ack = 1'b1;
                    wt = $urandom_range(0, 3);
                end else wt--;
            end else if_b.coin_ack = 1'b0;
        end
    end

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
        end
    endtask

    // Greedy payout with plain arithmetic: largest coin that fits and is in stock.
    task automatic model_pay(input int d, input int amt, input bit acks);
        int vals [3] = '{5, 10, 20};
        int rem;
        exp_n[d]   = 0;
        exp_flt[d] = 1'b0;
        exp_req[d] = 0;
        if (amt == 0) rem = 0;
        else if (amt % 5 != 0) begin
            exp_flt[d] = 1'b1;
            rem = 0;
        end else begin
            rem = amt;
            while (rem > 0) begin
                int pick;
                pick = -1;
                for (int i = 2; i >= 0; i--)
                    if (pick < 0 && vals[i] <= rem && stk[d][i] > 0) pick = i;
                if (pick < 0) begin
                    exp_flt[d] = 1'b1;
                    break;
                end
                if (!acks) begin
                    exp_flt[d] = 1'b1;
                    exp_req[d] = ACK_TO;
                    break;
                end
                exp_log[d][exp_n[d]] = (pick + 1) * 64 + rem;
                exp_n[d]++;
                stk[d][pick]--;
                rem -= vals[pick];
            end
        end
        exp_rem[d] = rem;
    endtask

    task automatic run_req(input int amt, input bit refill_too, input bit acks, input bit noise, input string tag);
        int base [2];
        bit seen [2] = '{0, 0};
        int lat  [2] = '{0, 0};
        int reqc [2] = '{0, 0};
        bit flt_o [2] = '{0, 0};
        int rem_o [2] = '{0, 0};
        ack_en = acks;
        for (int d = 0; d < 2; d++) begin
            if (refill_too) for (int i = 0; i < 3; i++) stk[d][i] = init_v[d];
            model_pay(d, amt, acks);
            base[d] = act_n[d];
        end
        @(negedge clk);
        cv = 1'b1;
        chg = AMT_W'(amt);
        rf = refill_too;
        @(negedge clk);
        cv = 1'b0;
        rf = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            nz = noise && (cyc == 4);
            for (int d = 0; d < 2; d++) begin
                if (req_v[d]) reqc[d]++;
                if (done_v[d] && !seen[d]) begin
                    seen[d]  = 1'b1;
                    lat[d]   = cyc;
                    flt_o[d] = flt_v[d];
                    rem_o[d] = int'(rem_v[d]);
                end
            end
            if (seen[0] && seen[1]) break;
            @(negedge clk);
        end
        nz = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check({tag, "_done_seen"}, d, seen[d], 1);
            check({tag, "_fault"}, d, flt_o[d], exp_flt[d]);
            check({tag, "_remaining"}, d, rem_o[d], exp_rem[d]);
            check({tag, "_empty"}, d, emp_v[d], {29'd0, stk[d][2] == 0, stk[d][1] == 0, stk[d][0] == 0});
            for (int i = 0; i < 3; i++) check({tag, "_stock"}, d, stk_v[d][i], stk[d][i]);
            check({tag, "_ncoins"}, d, act_n[d] - base[d], exp_n[d]);
            for (int k = 0; k < exp_n[d] && base[d] + k < act_n[d] && base[d] + k < LOGN; k++)
                check({tag, "_coin_rem"}, d, act_log[d][base[d] + k], exp_log[d][k]);
            if (!acks || exp_n[d] == 0) check({tag, "_req_cycles"}, d, reqc[d], exp_req[d]);
            if (amt == 0 || amt % 5 != 0) check({tag, "_done_latency"}, d, lat[d], 1);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_done_pulse"}, d, done_v[d], 0);
            check({tag, "_ready_after"}, d, rdy_v[d], 1);
        end
    endtask

    initial begin
        bit got_req;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 3; i++) stk[d][i] = init_v[d];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", d, rdy_v[d], 1);
            check("rst_coin_req", d, req_v[d], 0);
            check("rst_done", d, done_v[d], 0);
            check("rst_fault", d, flt_v[d], 0);
            check("rst_remaining", d, rem_v[d], 0);
            check("rst_empty", d, emp_v[d], 0);
            for (int i = 0; i < 3; i++) check("rst_stock", d, stk_v[d][i], init_v[d]);
        end

        run_req(35, 1'b0, 1'b1, 1'b0, "pay35");
        run_req(50, 1'b1, 1'b1, 1'b0, "pay50");
        run_req(20, 1'b0, 1'b0, 1'b1, "timeout20");
        run_req(40, 1'b1, 1'b1, 1'b0, "pay40_refill");
        run_req(7,  1'b0, 1'b1, 1'b0, "odd7");
        run_req(0,  1'b0, 1'b1, 1'b0, "zero");
        repeat (24) run_req($urandom_range(0, 63), ($urandom_range(0, 3) == 0), 1'b1, 1'b0, "rand");

        // Reset in the middle of a payout.
        ack_en = 1'b0;
        @(negedge clk);
        cv = 1'b1;
        chg = 6'd35;
        rf = 1'b1;
        @(negedge clk);
        cv = 1'b0;
        rf = 1'b0;
        got_req = 1'b0;
        for (int cyc = 0; cyc < 10 && !got_req; cyc++) begin
            if (req_v[0]) got_req = 1'b1;
            else @(negedge clk);
        end
        check("midrst_req_seen", 0, got_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) stk[d][i] = init_v[d];
            check("midrst_ready", d, rdy_v[d], 1);
            check("midrst_coin_req", d, req_v[d], 0);
            check("midrst_remaining", d, rem_v[d], 0);
            check("midrst_fault", d, flt_v[d], 0);
            check("midrst_done", d, done_v[d], 0);
            check("midrst_empty", d, emp_v[d], 0);
            for (int i = 0; i < 3; i++) check("midrst_stock", d, stk_v[d][i], init_v[d]);
        end
        run_req(10, 1'b0, 1'b1, 1'b0, "post_rst10");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
